// File: rtl/laser500_pkg.sv
// Shared encodings for the Laser 500 SDRAM slot arbiter: requester IDs,
// arbiter FSM states and the default slot length.
package laser500_pkg;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_DIO  = 2'd1,
      GNT_CPU  = 2'd2,
      GNT_VID  = 2'd3
   } gnt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int SLOT_LEN_DEFAULT = 8;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester and SDRAM system-port bundle seen by the slot arbiter.
// The arbiter uses the slave modport; requesters and the controller use master.
interface sdram_arbiter_if #(
   parameter int ADDR_W = 25
);

   logic              dio_req;
   logic [ADDR_W-1:0] dio_addr;
   logic [7:0]        dio_din;
   logic              dio_ack;

   logic              cpu_req;
   logic              cpu_we;
   logic [15:0]       cpu_addr;
   logic [7:0]        cpu_din;
   logic [7:0]        cpu_dout;
   logic              cpu_ack;

   logic              vid_req;
   logic [15:0]       vid_addr;
   logic [7:0]        vid_dout;
   logic              vid_ack;

   logic [ADDR_W-1:0] sd_addr;
   logic [7:0]        sd_din;
   logic              sd_we;
   logic              sd_oe;
   logic [7:0]        sd_dout;

   modport slave (
      input  dio_req, dio_addr, dio_din,
      output dio_ack,
      input  cpu_req, cpu_we, cpu_addr, cpu_din,
      output cpu_dout, cpu_ack,
      input  vid_req, vid_addr,
      output vid_dout, vid_ack,
      output sd_addr, sd_din, sd_we, sd_oe,
      input  sd_dout
   );

   modport master (
      output dio_req, dio_addr, dio_din,
      input  dio_ack,
      output cpu_req, cpu_we, cpu_addr, cpu_din,
      input  cpu_dout, cpu_ack,
      output vid_req, vid_addr,
      input  vid_dout, vid_ack,
      input  sd_addr, sd_din, sd_we, sd_oe,
      output sd_dout
   );

endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational grant selection: download always wins, CPU and video
// alternate on a tie using the last CPU/video winner.
module sdram_arb_pick
   import laser500_pkg::*;
(
   input  logic i_dioReq,
   input  logic i_cpuReq,
   input  logic i_vidReq,
   input  gnt_t i_lastGrant,
   output gnt_t o_grant
);

   always_comb begin
      o_grant = GNT_NONE;
      if (i_dioReq) begin
         o_grant = GNT_DIO;
      end else if (i_cpuReq && i_vidReq) begin
         o_grant = (i_lastGrant == GNT_CPU) ? GNT_VID : GNT_CPU;
      end else if (i_cpuReq) begin
         o_grant = GNT_CPU;
      end else if (i_vidReq) begin
         o_grant = GNT_VID;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Time-slot arbiter sharing one SDRAM system port between download, CPU and
// video; one access per CPU-clock slot, acked on the last cycle of the slot.
module sdram_arbiter
   import laser500_pkg::*;
#(
   parameter int SLOT_LEN = SLOT_LEN_DEFAULT,
   parameter int ADDR_W   = 25
)(
   input  logic           clk,
   input  logic           reset,
   input  logic           clkref,
   sdram_arbiter_if.slave bus
);

   localparam logic [3:0] LAST_WAIT = 4'(SLOT_LEN - 2);

   state_t            r_state;
   logic [3:0]        r_slotCnt;
   logic              r_clkrefD;
   gnt_t              r_grant;
   gnt_t              r_lastGrant;
   logic [ADDR_W-1:0] r_sdAddr;
   logic [7:0]        r_sdDin;
   logic              r_sdWe;
   logic              r_sdOe;
   logic [7:0]        r_cpuDout;
   logic [7:0]        r_vidDout;
   logic              r_dioAck;
   logic              r_cpuAck;
   logic              r_vidAck;

   logic              w_edge;
   logic              w_start;
   gnt_t              w_pick;
   logic [ADDR_W-1:0] w_addr;
   logic [7:0]        w_din;
   logic              w_we;
   logic              w_oe;

   assign w_edge  = clkref & ~r_clkrefD;
   assign w_start = w_edge && (w_pick != GNT_NONE);

   sdram_arb_pick u_pick (
      .i_dioReq    (bus.dio_req),
      .i_cpuReq    (bus.cpu_req),
      .i_vidReq    (bus.vid_req),
      .i_lastGrant (r_lastGrant),
      .o_grant     (w_pick)
   );

   // SDRAM command for whichever requester would win right now
   always_comb begin
      w_addr = '0;
      w_din  = '0;
      w_we   = 1'b0;
      w_oe   = 1'b0;
      case (w_pick)
         GNT_DIO: begin
            w_addr = bus.dio_addr;
            w_din  = bus.dio_din;
            w_we   = 1'b1;
         end
         GNT_CPU: begin
            w_addr = ADDR_W'(bus.cpu_addr);
            w_din  = bus.cpu_din;
            w_we   = bus.cpu_we;
            w_oe   = !bus.cpu_we;
         end
         GNT_VID: begin
            w_addr = ADDR_W'(bus.vid_addr);
            w_oe   = 1'b1;
         end
         default: ;
      endcase
   end

   // The slot boundary coincides with the DONE cycle of the previous slot,
   // so DONE makes the same grant decision as IDLE to keep slots back-to-back.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_slotCnt   <= '0;
         r_clkrefD   <= clkref;
         r_grant     <= GNT_NONE;
         r_lastGrant <= GNT_VID;
         r_sdAddr    <= '0;
         r_sdDin     <= '0;
         r_sdWe      <= 1'b0;
         r_sdOe      <= 1'b0;
         r_cpuDout   <= '0;
         r_vidDout   <= '0;
         r_dioAck    <= 1'b0;
         r_cpuAck    <= 1'b0;
         r_vidAck    <= 1'b0;
      end else begin
         r_clkrefD <= clkref;
         r_dioAck  <= 1'b0;
         r_cpuAck  <= 1'b0;
         r_vidAck  <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               r_state   <= IDLE;
               r_slotCnt <= '0;
               r_sdWe    <= 1'b0;
               r_sdOe    <= 1'b0;
               if (w_start) begin
                  r_state  <= ISSUE;
                  r_grant  <= w_pick;
                  r_sdAddr <= w_addr;
                  r_sdDin  <= w_din;
                  r_sdWe   <= w_we;
                  r_sdOe   <= w_oe;
                  if (w_pick == GNT_CPU || w_pick == GNT_VID) begin
                     r_lastGrant <= w_pick;
                  end
               end
            end
            ISSUE: begin
               r_slotCnt <= r_slotCnt + 4'd1;
               if (r_slotCnt == 4'd1) begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               r_slotCnt <= r_slotCnt + 4'd1;
               if (r_slotCnt == LAST_WAIT) begin
                  r_state <= DONE;
                  r_sdWe  <= 1'b0;
                  r_sdOe  <= 1'b0;
                  case (r_grant)
                     GNT_DIO: r_dioAck <= 1'b1;
                     GNT_CPU: begin
                        r_cpuAck <= 1'b1;
                        if (r_sdOe) begin
                           r_cpuDout <= bus.sd_dout;
                        end
                     end
                     GNT_VID: begin
                        r_vidAck  <= 1'b1;
                        r_vidDout <= bus.sd_dout;
                     end
                     default: ;
                  endcase
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.sd_addr  = r_sdAddr;
   assign bus.sd_din   = r_sdDin;
   assign bus.sd_we    = r_sdWe;
   assign bus.sd_oe    = r_sdOe;
   assign bus.cpu_dout = r_cpuDout;
   assign bus.vid_dout = r_vidDout;
   assign bus.dio_ack  = r_dioAck;
   assign bus.cpu_ack  = r_cpuAck;
   assign bus.vid_ack  = r_vidAck;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Slot-level bench for sdram_arbiter: each slot is predicted from the request
// levels at the slot boundary and checked cycle by cycle.
module tb_sdram_arbiter;

   localparam int SLOT = 8;
   localparam int AW   = 25;
   localparam int HALF = 5;

   logic clk;
   logic reset;
   logic clkref;

   int testCount = 0;
   int failCount = 0;

   bit         mCpuTurn = 1'b1;
   logic [7:0] mCpuDout = 8'h00;
   logic [7:0] mVidDout = 8'h00;

   sdram_arbiter_if #(.ADDR_W(AW)) bus ();

   sdram_arbiter #(.SLOT_LEN(SLOT), .ADDR_W(AW)) dut (
      .clk    (clk),
      .reset  (reset),
      .clkref (clkref),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #HALF clk = ~clk;
   end

   // CPU clock: SLOT ram clocks per period, edges offset from clk edges
   initial begin
      clkref = 1'b0;
      #1;
      forever #(SLOT * HALF) clkref = ~clkref;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One slot: drive requests at the boundary, then check all SLOT cycles.
   // win: 0 none, 1 download, 2 cpu, 3 video
   task automatic applyStimulus(input bit dio, input bit cpu, input bit vid, input bit we,
                                input logic [AW-1:0] dA, input logic [15:0] cA, input logic [15:0] vA,
                                input logic [7:0] dD, input logic [7:0] cD, input logic [7:0] sdD,
                                input int dropAt, input int resetAt);
      int              win;
      bit              aborted;
      logic [AW-1:0]   eAddr;
      logic [7:0]      eDin;
      bit              eWe;
      bit              eOe;
      @(posedge clkref);
      bus.dio_req  = dio;
      bus.dio_addr = dA;
      bus.dio_din  = dD;
      bus.cpu_req  = cpu;
      bus.cpu_we   = we;
      bus.cpu_addr = cA;
      bus.cpu_din  = cD;
      bus.vid_req  = vid;
      bus.vid_addr = vA;
      bus.sd_dout  = sdD;

      if (dio) win = 1;
      else if (cpu && vid) begin
         win = mCpuTurn ? 2 : 3;
         mCpuTurn = !mCpuTurn;
      end else if (cpu) begin
         win = 2;
         mCpuTurn = 1'b0;
      end else if (vid) begin
         win = 3;
         mCpuTurn = 1'b1;
      end else win = 0;

      eAddr = '0; eDin = '0; eWe = 1'b0; eOe = 1'b0;
      case (win)
         1: begin eAddr = dA; eDin = dD; eWe = 1'b1; end
         2: begin eAddr = AW'(cA); eDin = cD; eWe = we; eOe = !we; end
         3: begin eAddr = AW'(vA); eOe = 1'b1; end
         default: ;
      endcase

      aborted = 1'b0;
      for (int i = 0; i < SLOT; i++) begin
         @(negedge clk);
         if (aborted) begin
            if (i == resetAt + 1) begin
               checkOutput("reset sd_addr", 32'(bus.sd_addr), 32'h0);
               checkOutput("reset sd_din", 32'(bus.sd_din), 32'h0);
            end
            checkOutput("abort sd_we", 32'(bus.sd_we), 32'h0);
            checkOutput("abort sd_oe", 32'(bus.sd_oe), 32'h0);
            checkOutput("abort dio_ack", 32'(bus.dio_ack), 32'h0);
            checkOutput("abort cpu_ack", 32'(bus.cpu_ack), 32'h0);
            checkOutput("abort vid_ack", 32'(bus.vid_ack), 32'h0);
         end else if (i < SLOT - 1) begin
            checkOutput("sd_we", 32'(bus.sd_we), 32'(eWe));
            checkOutput("sd_oe", 32'(bus.sd_oe), 32'(eOe));
            if (win != 0) checkOutput("sd_addr", 32'(bus.sd_addr), 32'(eAddr));
            if (win == 1 || (win == 2 && we)) checkOutput("sd_din", 32'(bus.sd_din), 32'(eDin));
            checkOutput("early dio_ack", 32'(bus.dio_ack), 32'h0);
            checkOutput("early cpu_ack", 32'(bus.cpu_ack), 32'h0);
            checkOutput("early vid_ack", 32'(bus.vid_ack), 32'h0);
         end else begin
            if (win == 2 && !we) mCpuDout = sdD;
            if (win == 3) mVidDout = sdD;
            checkOutput("done sd_we", 32'(bus.sd_we), 32'h0);
            checkOutput("done sd_oe", 32'(bus.sd_oe), 32'h0);
            checkOutput("dio_ack", 32'(bus.dio_ack), 32'(win == 1));
            checkOutput("cpu_ack", 32'(bus.cpu_ack), 32'(win == 2));
            checkOutput("vid_ack", 32'(bus.vid_ack), 32'(win == 3));
         end
         checkOutput("cpu_dout", 32'(bus.cpu_dout), 32'(mCpuDout));
         checkOutput("vid_dout", 32'(bus.vid_dout), 32'(mVidDout));

         // After the grant, changes on requester inputs must not leak through
         if (i == 1 && !aborted) begin
            bus.dio_addr = AW'($urandom);
            bus.dio_din  = 8'($urandom);
            bus.cpu_we   = ~bus.cpu_we;
            bus.cpu_addr = 16'($urandom);
            bus.cpu_din  = 8'($urandom);
            bus.vid_addr = 16'($urandom);
         end
         if (i == dropAt) begin
            bus.dio_req = 1'b0;
            bus.cpu_req = 1'b0;
            bus.vid_req = 1'b0;
         end
         if (aborted && i == resetAt + 1) reset = 1'b0;
         if (i == resetAt) begin
            reset    = 1'b1;
            aborted  = 1'b1;
            mCpuDout = 8'h00;
            mVidDout = 8'h00;
            mCpuTurn = 1'b1;
         end
      end
   endtask

   initial begin
      reset        = 1'b1;
      bus.dio_req  = 1'b0;
      bus.dio_addr = '0;
      bus.dio_din  = '0;
      bus.cpu_req  = 1'b0;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = '0;
      bus.cpu_din  = '0;
      bus.vid_req  = 1'b0;
      bus.vid_addr = '0;
      bus.sd_dout  = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst sd_addr", 32'(bus.sd_addr), 32'h0);
      checkOutput("rst sd_din", 32'(bus.sd_din), 32'h0);
      checkOutput("rst sd_we", 32'(bus.sd_we), 32'h0);
      checkOutput("rst sd_oe", 32'(bus.sd_oe), 32'h0);
      checkOutput("rst dio_ack", 32'(bus.dio_ack), 32'h0);
      checkOutput("rst cpu_ack", 32'(bus.cpu_ack), 32'h0);
      checkOutput("rst vid_ack", 32'(bus.vid_ack), 32'h0);
      checkOutput("rst cpu_dout", 32'(bus.cpu_dout), 32'h0);
      checkOutput("rst vid_dout", 32'(bus.vid_dout), 32'h0);
      reset = 1'b0;

      // cpu/video tie held over four slots: cpu first after reset, then alternate
      for (int s = 0; s < 4; s++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 16'h1111, 16'h2222, 8'h00, 8'h00,
                       8'(8'h30 + s), -1, -1);
      end

      // cpu read and cpu write
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 16'h8123, 16'h0000, 8'h00, 8'h00, 8'hA5, -1, -1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0, 16'hC000, 16'h0000, 8'h00, 8'h5A, 8'hEE, -1, -1);

      // download holds priority for three slots while everyone requests
      for (int s = 0; s < 3; s++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, AW'(25'h1ABCDE0 + s), 16'h4000, 16'h5000,
                       8'(8'hC0 + s), 8'h11, 8'h22, -1, -1);
      end

      // video request dropped mid-slot still completes, next slot idle
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 16'h0000, 16'h3456, 8'h00, 8'h00, 8'h9C, 2, -1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0000, 16'h0000, 8'h00, 8'h00, 8'h00, -1, -1);

      // reset during a video read abandons it; grant resumes at next boundary
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 16'h0000, 16'h7777, 8'h00, 8'h00, 8'h77, -1, 3);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 16'h0000, 16'h7778, 8'h00, 8'h00, 8'h78, -1, -1);

      for (int s = 0; s < 40; s++) begin
         int dropAt;
         dropAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SLOT - 2)) : -1;
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       AW'($urandom), 16'($urandom), 16'($urandom),
                       8'($urandom), 8'($urandom), 8'($urandom), dropAt, -1);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter SLOT_LEN, default 8: clk cycles per SDRAM slot; equals the ram_clock/cpu_clock ratio; legal range 4..16.
REQ-002 Parameter ADDR_W, default 25: SDRAM byte-address width.
REQ-003 clk  in  1  ram clock (32 MHz); all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 clkref  in  1  CPU clock (cpu_clock); its rising edge marks a slot boundary.
REQ-006 dio_req  in  1  download write request (level); dio_addr  in  ADDR_W; dio_din  in  8; dio_ack  out  1  one-cycle completion pulse.
REQ-007 cpu_req  in  1  CPU request (level); cpu_we  in  1  1=write; cpu_addr  in  16; cpu_din  in  8; cpu_dout  out  8; cpu_ack  out  1  one-cycle completion pulse.
REQ-008 vid_req  in  1  video fetch request, read-only (level); vid_addr  in  16; vid_dout  out  8; vid_ack  out  1  one-cycle completion pulse.
REQ-009 sd_addr  out  ADDR_W; sd_din  out  8; sd_we  out  1; sd_oe  out  1; sd_dout  in  8; connects to the sdram controller system port.

Function
REQ-010 Arbiter SHALL detect the clkref rising edge by comparing clkref with its one-cycle-delayed copy; the cycle after detection is slot cycle 0.
REQ-011 FSM states: IDLE, ISSUE, WAIT, DONE.
REQ-012 IDLE: on slot cycle 0, with any request pending, SHALL latch a grant and go to ISSUE; otherwise stay in IDLE with sd_we=sd_oe=0.
REQ-013 Priority: dio highest, always; cpu and vid SHALL alternate (round-robin) when both are pending; a last_grant flag records the winner, reset value = vid, so cpu wins the first tie.
REQ-014 ISSUE (slot cycle 0..1): drive sd_addr/sd_din/sd_we/sd_oe from the granted requester; addr zero-extended from 16 bits for cpu and vid; dio: sd_we=1, sd_oe=0; cpu: sd_we=cpu_we, sd_oe=!cpu_we; vid: sd_we=0, sd_oe=1.
REQ-015 Granted requester inputs SHALL be registered at grant; later changes within the slot SHALL be ignored.
REQ-016 WAIT: hold SDRAM outputs stable until slot cycle SLOT_LEN-2.
REQ-017 DONE (slot cycle SLOT_LEN-1): read grants SHALL capture sd_dout into cpu_dout or vid_dout; the granted ack SHALL pulse high for exactly this cycle; sd_we and sd_oe SHALL deassert; next state IDLE.
REQ-018 Latency: request present at slot cycle 0 -> ack at slot cycle SLOT_LEN-1 of the same slot; at most one access per slot.
REQ-019 A request still high on the cycle after its ack SHALL be treated as a new request for the next slot.
REQ-020 A request dropped mid-slot SHALL NOT abort the slot; the ack still pulses.
REQ-021 cpu_dout and vid_dout SHALL hold their last captured value until the next read for that requester.
REQ-022 A clkref edge arriving outside IDLE SHALL be ignored; the slot completes on its own counter.
REQ-023 At most one ack SHALL be high in any cycle.

Reset
REQ-024 During reset, state=IDLE, slot counter=0, all acks=0, sd_we=sd_oe=0, sd_addr=0, sd_din=0, cpu_dout=vid_dout=0, last_grant=vid.
REQ-025 Reset asserted mid-slot SHALL abandon the access on the next clk edge, with no ack.
REQ-026 After reset deasserts, the first grant SHALL occur at the next detected clkref rising edge.

Structure
REQ-027 Shared package laser500_pkg SHALL hold the requester ID encoding (GNT_NONE, GNT_DIO, GNT_CPU, GNT_VID), the FSM state encoding, and SLOT_LEN_DEFAULT=8.
REQ-028 One combinational sub-module, sdram_arb_pick, SHALL compute the next grant from the three requests and last_grant; the FSM, counter, and datapath registers stay in sdram_arbiter.

Verification
REQ-029 cpu read only: cpu_req=1, cpu_we=0, cpu_addr=16'h8123, sd_dout=8'hA5 -> sd_addr=25'h0008123, sd_oe=1 in cycles 0..6, cpu_ack at cycle 7, cpu_dout=8'hA5.
REQ-030 All three requesting at the same slot edge -> dio granted (sd_we=1) for three consecutive slots while dio_req is held; cpu and vid stall with no ack.
REQ-031 cpu and vid both held over 4 slots -> grants cpu, vid, cpu, vid; one ack per slot.
REQ-032 cpu write 8'h5A to 16'hC000 -> sd_we=1, sd_oe=0, sd_din=8'h5A; cpu_dout unchanged after cpu_ack.
REQ-033 reset pulsed at slot cycle 3 of a vid read -> no vid_ack, outputs at reset values next cycle, next grant only after the following clkref edge.
REQ-034 vid_req dropped at slot cycle 2 -> vid_ack still pulses at cycle 7; the next slot is idle unless another request is pending.
